mdu_unit: RTL and testbench

- Execute-stage multiply/divide unit. Sits beside the ALU and takes the same forwarded srcA/srcB operand buses.
- Holds the architectural HI/LO registers and models the multi-cycle latency of MULT/MULTU/DIV/DIVU.
- Its busy output drives the hazard unit's stall logic.
- Its MDUout result joins the E-stage result mux alongside the ALU's outC.

---
 rtl/mdu_unit.sv | 168 ++++++++++++++++
 tb/tb_mdu_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit -- execute-stage multiply/divide unit
//
// Owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU are computed at
// the accept edge into a pending {hi,lo} pair. That pair is committed to HI/LO
// only after the modelled latency expires. busy feeds the hazard unit stall,
// and MDUout joins the E-stage result mux.
//
// Ports
//   clk     in   1   rising-edge system clock
//   reset   in   1   asynchronous, active-low reset
//   start   in   1   operation valid (qualifies MDUOp 0-3, 6-7)
//   MDUOp   in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO,
//                    6 MTHI, 7 MTLO
//   srcA    in  32   rs operand (dividend / multiplicand / MTHI-MTLO data)
//   srcB    in  32   rt operand (divisor / multiplier)
//   busy    out  1   registered; high while a mult/div is in flight
//   HI      out 32   HI register
//   LO      out 32   LO register
//   MDUout  out 32   HI for MFHI, LO for MFLO, otherwise 0
// -----------------------------------------------------------------------------
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUout
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] counter;
    logic [31:0]      pendHi;
    logic [31:0]      pendLo;
    logic             pendWrite;   // cleared for divide-by-zero: HI/LO stay put

    logic             accept;
    logic             isSignedDiv;
    logic             divByZero;
    logic [63:0]      prodS;
    logic [63:0]      prodU;
    logic [31:0]      magA;
    logic [31:0]      magB;
    logic [31:0]      quotU;
    logic [31:0]      remU;
    logic [31:0]      quot;
    logic [31:0]      rem;
    logic [63:0]      opResult;

    assign accept      = start && !busy;
    assign isSignedDiv = (MDUOp == OP_DIV);
    assign divByZero   = (srcB == 32'd0);

    // -------------------------------------------------------------------------
    // Result datapath, evaluated on the operands present at the accept edge.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        prodS    = 64'd0;
        prodU    = 64'd0;
        magA     = srcA;
        magB     = srcB;
        quotU    = 32'd0;
        remU     = 32'd0;
        quot     = 32'd0;
        rem      = 32'd0;
        opResult = 64'd0;

        // Low 64 bits of a sign-extended product equal the signed product.
        prodS = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
        prodU = {32'd0, srcA} * {32'd0, srcB};

        // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow of
        // a native signed divide, and naturally yields 0x80000000 / 0 there.
        if (isSignedDiv && srcA[31]) magA = -srcA;
        if (isSignedDiv && srcB[31]) magB = -srcB;
        if (!divByZero) begin
            quotU = magA / magB;
            remU  = magA % magB;
        end
        quot = (isSignedDiv && (srcA[31] ^ srcB[31])) ? -quotU : quotU;
        rem  = (isSignedDiv && srcA[31])              ? -remU  : remU;

        case (MDUOp)
            OP_MULT:  opResult = prodS;
            OP_MULTU: opResult = prodU;
            OP_DIV,
            OP_DIVU:  opResult = {rem, quot};
            default:  opResult = 64'd0;
        endcase
    end

    // -------------------------------------------------------------------------
    // HI/LO, pending result and latency counter.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Pending result is cleared too, so an aborted op can never land.
            HI        <= 32'd0;
            LO        <= 32'd0;
            busy      <= 1'b0;
            counter   <= '0;
            pendHi    <= 32'd0;
            pendLo    <= 32'd0;
            pendWrite <= 1'b0;
        end else if (busy) begin
            // NOTE: non-blocking assignments so every register here updates
            // from pre-edge values, independent of statement order.
            counter <= counter - CNT_W'(1);
            if (counter == CNT_W'(1)) begin
                busy <= 1'b0;
                if (pendWrite) begin
                    HI <= pendHi;
                    LO <= pendLo;
                end
            end
        end else if (accept) begin
            case (MDUOp)
                OP_MULT, OP_MULTU: begin
                    pendHi    <= opResult[63:32];
                    pendLo    <= opResult[31:0];
                    pendWrite <= 1'b1;
                    counter   <= CNT_W'(MULT_CYCLES);
                    busy      <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    pendHi    <= opResult[63:32];
                    pendLo    <= opResult[31:0];
                    pendWrite <= !divByZero;
                    counter   <= CNT_W'(DIV_CYCLES);
                    busy      <= 1'b1;
                end
                OP_MTHI: HI <= srcA;
                OP_MTLO: LO <= srcA;
                default: ;  // MFHI/MFLO: read-only
            endcase
        end
    end

    // MFHI/MFLO read path; independent of start and busy.
    always_comb begin
        case (MDUOp)
            OP_MFHI: MDUout = HI;
            OP_MFLO: MDUout = LO;
            default: MDUout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_unit.sv
// -----------------------------------------------------------------------------
// tb_mdu_unit -- scoreboard bench for mdu_unit
//
// The stimulus pushes the hand-computed HI/LO and busy length of each
// mult/div. A monitor counts busy cycles on falling clock edges. It pops and
// compares an entry whenever busy drops. Register-move, read-port and reset
// checks are done inline.
// -----------------------------------------------------------------------------
module tb_mdu_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } expect_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUout;

    expect_t sb[$];
    int      nCompared;
    int      nMismatched;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MDUOp  (MDUOp),
        .srcA   (srcA),
        .srcB   (srcB),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .MDUout (MDUout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Holds start for exactly one rising edge (the accept edge), returns #1
    // after it, then scrambles the operands to show they were sampled once.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        MDUOp = op;
        srcA  = a;
        srcB  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        MDUOp = 3'd0;
        srcA  = 32'h5A5A_1234;
        srcB  = 32'h0000_0003;
    endtask

    task automatic expectOp(input logic [31:0] hi, input logic [31:0] lo, input int cycles);
        expect_t e;
        e.hi     = hi;
        e.lo     = lo;
        e.cycles = cycles;
        sb.push_back(e);
    endtask

    // Bounded wait for busy to drop.
    task automatic waitIdle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    // Monitor: compares each completion against the scoreboard.
    initial begin : monitor
        logic    prevBusy;
        int      busyCnt;
        expect_t e;
        prevBusy = 1'b0;
        busyCnt  = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prevBusy = 1'b0;
                busyCnt  = 0;
            end else begin
                if (busy) busyCnt++;
                if (prevBusy && !busy) begin
                    if (sb.size() == 0) begin
                        check("unexpected completion", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("completion HI", HI, e.hi);
                        check("completion LO", LO, e.lo);
                        check("busy length", busyCnt, e.cycles);
                    end
                    busyCnt = 0;
                end
                prevBusy = busy;
            end
        end
    end

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset = 1'b0;
        start = 1'b0;
        MDUOp = 3'd0;
        srcA  = 32'd0;
        srcB  = 32'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        reset = 1'b1;

        // MULT: -1 * -2^31 = +2^31.
        expectOp(32'h0000_0000, 32'h8000_0000, 5);
        issue(3'd0, 32'hFFFF_FFFF, 32'h8000_0000);
        waitIdle();

        // MULTU with an MTHI presented on the edge busy falls (must be ignored).
        expectOp(32'h7FFF_FFFF, 32'h8000_0000, 5);
        issue(3'd1, 32'hFFFF_FFFF, 32'h8000_0000);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        MDUOp = 3'd6;
        srcA  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();
        check("late MTHI ignored", HI, 32'h7FFF_FFFF);

        // MFHI / MFLO / non-read op on MDUout.
        MDUOp = 3'd4;
        #1;
        check("MFHI", MDUout, 32'h7FFF_FFFF);
        MDUOp = 3'd5;
        #1;
        check("MFLO", MDUout, 32'h8000_0000);
        MDUOp = 3'd2;
        #1;
        check("MDUout other op", MDUout, 32'd0);

        // DIV -7 / 2 -> q=-3, r=-1.
        expectOp(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        waitIdle();

        // DIVU 0xFFFFFFF9 / 2.
        expectOp(32'h0000_0001, 32'h7FFF_FFFC, 10);
        issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        waitIdle();

        // DIV INT_MIN / -1 wraps.
        expectOp(32'h0000_0000, 32'h8000_0000, 10);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle();

        // MTHI / MTLO: one edge each, no busy.
        issue(3'd6, 32'h1234_5678, 32'd0);
        check("MTHI HI", HI, 32'h1234_5678);
        check("MTHI busy", {31'd0, busy}, 32'd0);
        issue(3'd7, 32'h9ABC_DEF0, 32'd0);
        check("MTLO LO", LO, 32'h9ABC_DEF0);
        check("MTLO keeps HI", HI, 32'h1234_5678);
        check("MTLO busy", {31'd0, busy}, 32'd0);

        // DIV by zero: full latency, HI/LO unchanged; MULT at busy cycle 3 ignored.
        expectOp(32'h1234_5678, 32'h9ABC_DEF0, 10);
        issue(3'd2, 32'h0000_0064, 32'h0000_0000);
        repeat (1) @(posedge clk);
        #1;
        start = 1'b1;
        MDUOp = 3'd0;
        srcA  = 32'h0000_0002;
        srcB  = 32'h0000_0003;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();
        check("no op after lockout", {31'd0, busy}, 32'd0);

        // Reset mid-op: asynchronous clear, no late write.
        issue(3'd0, 32'h0000_0007, 32'h0000_0003);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset HI", HI, 32'd0);
        check("async reset LO", LO, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("no late write HI", HI, 32'd0);
        check("no late write LO", LO, 32'd0);
        check("no late busy", {31'd0, busy}, 32'd0);

        check("scoreboard drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
